// File: rtl/rst_ckpt_pkg.sv
// Shared defaults and types for the register status table with branch checkpoints.
package rst_ckpt_pkg;

    localparam int NUM_REGS_DEF  = 32;
    localparam int ADDR_W_DEF    = 5;
    localparam int TAG_W_DEF     = 6;
    localparam int ZERO_REG_ADDR = 0;

    typedef struct packed {
        logic                 pend;
        logic [TAG_W_DEF-1:0] tag;
    } rst_entry_t;

endpackage

// File: rtl/rst_ckpt_slot.sv
// One checkpoint bank: captures a live-table snapshot and keeps clearing entries on CDB hits.
module rst_ckpt_slot
    import rst_ckpt_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           save_en,
    input  logic [NUM_REGS-1:0]            save_pend,
    input  logic [NUM_REGS-1:0][TAG_W-1:0] save_tag,
    input  logic                           cdb_valid,
    input  logic [TAG_W-1:0]               cdb_tag,
    output logic [NUM_REGS-1:0]            snap_pend,
    output logic [NUM_REGS-1:0][TAG_W-1:0] snap_tag
);

    logic [NUM_REGS-1:0]            spend_q, spend_d;
    logic [NUM_REGS-1:0][TAG_W-1:0] stag_q, stag_d;
    logic [NUM_REGS-1:0]            hit_s;

    // Snapshot entries whose producer broadcasts this cycle
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            hit_s[i] = cdb_valid && spend_q[i] && (stag_q[i] == cdb_tag);
        end
    end

    // Read-out already has this cycle's CDB clear applied, so a restore sees it
    assign snap_pend = spend_q & ~hit_s;
    assign snap_tag  = stag_q;

    // Next snapshot contents: fresh capture or cleared hold
    always_comb begin
        spend_d = snap_pend;
        stag_d  = stag_q;
        if (save_en) begin
            spend_d = save_pend;
            stag_d  = save_tag;
        end else begin
            spend_d = snap_pend;
            stag_d  = stag_q;
        end
    end

    // Snapshot storage
    always_ff @(posedge clk) begin
        if (reset) begin
            spend_q <= '0;
            stag_q  <= '0;
        end else begin
            spend_q <= spend_d;
            stag_q  <= stag_d;
        end
    end

endmodule

// File: rtl/rst_ckpt.sv
// Register status table: per-register producer tag and pending bit, CDB clearing,
// two bypassed source lookups and NUM_CKPT single-cycle restorable checkpoints.
module rst_ckpt
    import rst_ckpt_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int NUM_CKPT = 4,
    parameter int CKPT_W   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TAG_W-1:0]    dispatch_tag,
    input  logic                dispatch_valid,
    input  logic [ADDR_W-1:0]   dispatch_addr,
    input  logic                dispatch_wen,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic                cdb_valid,
    output logic [NUM_REGS-1:0] regfile_wen_onehot,
    input  logic [ADDR_W-1:0]   dispatch_rsaddr,
    input  logic [ADDR_W-1:0]   dispatch_rtaddr,
    output logic [TAG_W-1:0]    dispatch_rstag,
    output logic [TAG_W-1:0]    dispatch_rttag,
    output logic                dispatch_rsvalid,
    output logic                dispatch_rtvalid,
    input  logic                ckpt_save,
    input  logic [CKPT_W-1:0]   ckpt_save_id,
    input  logic                ckpt_restore,
    input  logic [CKPT_W-1:0]   ckpt_restore_id
);

    logic [NUM_REGS-1:0]            pend_q, pend_d;
    logic [NUM_REGS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [NUM_REGS-1:0]            cdb_hit_s;
    logic [NUM_REGS-1:0]            live_clr_pend_s;
    logic                           dispatch_we_s;
    logic [NUM_CKPT-1:0]            save_sel_s;
    logic [NUM_REGS-1:0]            slot_pend_s [NUM_CKPT];
    logic [NUM_REGS-1:0][TAG_W-1:0] slot_tag_s  [NUM_CKPT];

    // CDB match against the live table; register 0 never matches when hard-wired
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cdb_hit_s[i] = cdb_valid && pend_q[i] && (tag_q[i] == cdb_tag)
                           && !((ZERO_REG != 0) && (i == ZERO_REG_ADDR));
        end
    end

    assign regfile_wen_onehot = cdb_hit_s;
    assign live_clr_pend_s    = pend_q & ~cdb_hit_s;
    assign dispatch_we_s      = dispatch_valid && dispatch_wen
                                && !((ZERO_REG != 0) && (dispatch_addr == ADDR_W'(ZERO_REG_ADDR)));

    assign dispatch_rsvalid = pend_q[dispatch_rsaddr] && !cdb_hit_s[dispatch_rsaddr];
    assign dispatch_rstag   = tag_q[dispatch_rsaddr];
    assign dispatch_rtvalid = pend_q[dispatch_rtaddr] && !cdb_hit_s[dispatch_rtaddr];
    assign dispatch_rttag   = tag_q[dispatch_rtaddr];

    // Snapshots capture the CDB-cleared table before this cycle's rename; a restore cancels any save
    genvar k;
    generate
        for (k = 0; k < NUM_CKPT; k++) begin : g_slot
            assign save_sel_s[k] = ckpt_save && !ckpt_restore && (ckpt_save_id == CKPT_W'(k));

            rst_ckpt_slot #(
                .NUM_REGS (NUM_REGS),
                .TAG_W    (TAG_W)
            ) u_slot (
                .clk       (clk),
                .reset     (reset),
                .save_en   (save_sel_s[k]),
                .save_pend (live_clr_pend_s),
                .save_tag  (tag_q),
                .cdb_valid (cdb_valid),
                .cdb_tag   (cdb_tag),
                .snap_pend (slot_pend_s[k]),
                .snap_tag  (slot_tag_s[k])
            );
        end
    endgenerate

    // Live-table next state: restore > dispatch write > CDB clear > hold
    always_comb begin
        pend_d = live_clr_pend_s;
        tag_d  = tag_q;
        if (ckpt_restore) begin
            pend_d = slot_pend_s[ckpt_restore_id];
            tag_d  = slot_tag_s[ckpt_restore_id];
        end else if (dispatch_we_s) begin
            pend_d[dispatch_addr] = 1'b1;
            tag_d[dispatch_addr]  = dispatch_tag;
        end else begin
            pend_d = live_clr_pend_s;
            tag_d  = tag_q;
        end
    end

    // Live-table storage
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            tag_q  <= '0;
        end else begin
            pend_q <= pend_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: tb/tb_rst_ckpt.sv
// Randomised scoreboard bench for rst_ckpt against an array-based reference table.
module tb_rst_ckpt;

    localparam int NR = 32;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  dispatch_tag = '0;
    logic        dispatch_valid = 1'b0;
    logic [4:0]  dispatch_addr = '0;
    logic        dispatch_wen = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic        cdb_valid = 1'b0;
    logic [31:0] regfile_wen_onehot;
    logic [4:0]  dispatch_rsaddr = '0;
    logic [4:0]  dispatch_rtaddr = '0;
    logic [5:0]  dispatch_rstag, dispatch_rttag;
    logic        dispatch_rsvalid, dispatch_rtvalid;
    logic        ckpt_save = 1'b0;
    logic [1:0]  ckpt_save_id = '0;
    logic        ckpt_restore = 1'b0;
    logic [1:0]  ckpt_restore_id = '0;

    rst_ckpt dut (
        .clk                (clk),
        .reset              (reset),
        .dispatch_tag       (dispatch_tag),
        .dispatch_valid     (dispatch_valid),
        .dispatch_addr      (dispatch_addr),
        .dispatch_wen       (dispatch_wen),
        .cdb_tag            (cdb_tag),
        .cdb_valid          (cdb_valid),
        .regfile_wen_onehot (regfile_wen_onehot),
        .dispatch_rsaddr    (dispatch_rsaddr),
        .dispatch_rtaddr    (dispatch_rtaddr),
        .dispatch_rstag     (dispatch_rstag),
        .dispatch_rttag     (dispatch_rttag),
        .dispatch_rsvalid   (dispatch_rsvalid),
        .dispatch_rtvalid   (dispatch_rtvalid),
        .ckpt_save          (ckpt_save),
        .ckpt_save_id       (ckpt_save_id),
        .ckpt_restore       (ckpt_restore),
        .ckpt_restore_id    (ckpt_restore_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wen;
        logic        rsv;
        logic [5:0]  rstag;
        logic        rtv;
        logic [5:0]  rttag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: live table and snapshots as plain arrays
    bit         m_pend [NR];
    logic [5:0] m_tag  [NR];
    bit         s_pend [NC][NR];
    logic [5:0] s_tag  [NC][NR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.wen = '0;
        for (int i = 0; i < NR; i++)
            if (cdb_valid && m_pend[i] && m_tag[i] == cdb_tag) e.wen[i] = 1'b1;
        e.rsv   = m_pend[dispatch_rsaddr] && !e.wen[dispatch_rsaddr];
        e.rstag = m_tag[dispatch_rsaddr];
        e.rtv   = m_pend[dispatch_rtaddr] && !e.wen[dispatch_rtaddr];
        e.rttag = m_tag[dispatch_rtaddr];
        return e;
    endfunction

    task automatic model_update();
        bit hit [NR];
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_pend[i] = 0; m_tag[i] = '0;
                for (int k = 0; k < NC; k++) begin s_pend[k][i] = 0; s_tag[k][i] = '0; end
            end
        end else begin
            for (int i = 0; i < NR; i++) hit[i] = cdb_valid && m_pend[i] && m_tag[i] == cdb_tag;
            for (int k = 0; k < NC; k++)
                for (int i = 0; i < NR; i++)
                    if (cdb_valid && s_pend[k][i] && s_tag[k][i] == cdb_tag) s_pend[k][i] = 0;
            if (ckpt_restore) begin
                for (int i = 0; i < NR; i++) begin
                    m_pend[i] = s_pend[ckpt_restore_id][i];
                    m_tag[i]  = s_tag[ckpt_restore_id][i];
                end
            end else begin
                for (int i = 0; i < NR; i++) if (hit[i]) m_pend[i] = 0;
                if (ckpt_save)
                    for (int i = 0; i < NR; i++) begin
                        s_pend[ckpt_save_id][i] = m_pend[i];
                        s_tag[ckpt_save_id][i]  = m_tag[i];
                    end
                if (dispatch_valid && dispatch_wen && dispatch_addr != 5'd0) begin
                    m_pend[dispatch_addr] = 1;
                    m_tag[dispatch_addr]  = dispatch_tag;
                end
            end
        end
    endtask

    // One cycle: push the expectation for the inputs now applied, then advance the model at the edge
    task automatic step(input bit do_chk);
        if (do_chk) q.push_back(predict());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; dispatch_valid = 1'b0; dispatch_wen = 1'b0; cdb_valid = 1'b0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
    endtask

    task automatic disp(input logic [4:0] a, input logic [5:0] t);
        dispatch_valid = 1'b1; dispatch_wen = 1'b1; dispatch_addr = a; dispatch_tag = t;
    endtask

    task automatic cdb(input logic [5:0] t);
        cdb_valid = 1'b1; cdb_tag = t;
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("regfile_wen_onehot", regfile_wen_onehot, e.wen);
                chk("rsvalid", {31'd0, dispatch_rsvalid}, {31'd0, e.rsv});
                chk("rstag",   {26'd0, dispatch_rstag},   {26'd0, e.rstag});
                chk("rtvalid", {31'd0, dispatch_rtvalid}, {31'd0, e.rtv});
                chk("rttag",   {26'd0, dispatch_rttag},   {26'd0, e.rttag});
            end
        end
    end

    initial begin
        int wait_cnt;
        reset = 1'b1;
        step(1'b0);
        step(1'b1);
        idle();
        dispatch_rsaddr = 5'd5; dispatch_rtaddr = 5'd6;
        step(1'b1);
        disp(5'd5, 6'd12); step(1'b1); idle();
        step(1'b1);
        cdb(6'd12); step(1'b1); idle();
        step(1'b1);
        dispatch_rsaddr = 5'd7; dispatch_rtaddr = 5'd0;
        disp(5'd7, 6'd9); step(1'b1); idle();
        disp(5'd7, 6'd3); cdb(6'd9); step(1'b1); idle();
        step(1'b1);
        disp(5'd0, 6'd1); step(1'b1); idle();
        cdb(6'd1); step(1'b1); idle();
        dispatch_rsaddr = 5'd2;
        for (int pass = 0; pass < 2; pass++) begin
            disp(5'd2, 6'd4); step(1'b1); idle();
            ckpt_save = 1'b1; ckpt_save_id = 2'd1; step(1'b1); idle();
            disp(5'd2, 6'd8); step(1'b1); idle();
            if (pass == 1) begin cdb(6'd4); step(1'b1); idle(); end
            ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; step(1'b1); idle();
            step(1'b1);
        end
        dispatch_rsaddr = 5'd9;
        disp(5'd9, 6'd5); step(1'b1); idle();
        ckpt_save = 1'b1; ckpt_save_id = 2'd2; step(1'b1); idle();
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd2; disp(5'd9, 6'd20);
        ckpt_save = 1'b1; ckpt_save_id = 2'd2; step(1'b1); idle();
        step(1'b1);
        reset = 1'b1; ckpt_restore = 1'b1; ckpt_restore_id = 2'd2; disp(5'd9, 6'd21); cdb(6'd5);
        step(1'b1); idle();
        step(1'b1);

        for (int n = 0; n < 1500; n++) begin
            reset           = ($urandom_range(0, 99) == 0);
            dispatch_valid  = ($urandom_range(0, 3) != 0);
            dispatch_wen    = ($urandom_range(0, 3) != 0);
            dispatch_addr   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            dispatch_tag    = 6'($urandom_range(0, 7));
            cdb_valid       = ($urandom_range(0, 1) != 0);
            cdb_tag         = 6'($urandom_range(0, 7));
            dispatch_rsaddr = 5'($urandom_range(0, 7));
            dispatch_rtaddr = 5'($urandom);
            ckpt_save       = ($urandom_range(0, 4) == 0);
            ckpt_save_id    = 2'($urandom);
            ckpt_restore    = ($urandom_range(0, 7) == 0);
            ckpt_restore_id = 2'($urandom);
            step(1'b1);
        end
        idle();

        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_ckpt.md
Name: rst_ckpt

Overview:
- Parametrised register status table (RST) for the Tomasulo dispatch stage.
- Per architectural register, holds the ROB tag of the youngest in-flight producer plus a pending bit.
- Serves two source-operand lookups (RS, RT), clears entries on CDB broadcast and drives one-hot register file write enables.
- Adds branch checkpoints: snapshot on branch dispatch, single-cycle restore on mispredict.

Parameters:
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register address width, clog2(NUM_REGS).
- TAG_W, 6, ROB tag width.
- NUM_CKPT, 4, number of checkpoint slots.
- CKPT_W, 2, checkpoint id width, clog2(NUM_CKPT).
- ZERO_REG, 1, when 1 register 0 is never pending.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- dispatch_tag  in  TAG_W  tag of the instruction being dispatched.
- dispatch_valid  in  1  dispatch slot holds a valid instruction.
- dispatch_addr  in  ADDR_W  destination register.
- dispatch_wen  in  1  instruction writes a destination; write occurs only when dispatch_valid && dispatch_wen.
- cdb_tag  in  TAG_W  tag broadcast on the CDB.
- cdb_valid  in  1  CDB broadcast valid.
- regfile_wen_onehot  out  NUM_REGS  bit i = CDB result is to be written into register i.
- dispatch_rsaddr / dispatch_rtaddr  in  ADDR_W  source register lookups.
- dispatch_rstag / dispatch_rttag  out  TAG_W  producer tag of the source.
- dispatch_rsvalid / dispatch_rtvalid  out  1  source is pending; tag output meaningful only when 1.
- ckpt_save  in  1  take a snapshot into slot ckpt_save_id.
- ckpt_save_id  in  CKPT_W  destination slot.
- ckpt_restore  in  1  restore live table from slot ckpt_restore_id (mispredict).
- ckpt_restore_id  in  CKPT_W  source slot.

Behaviour:
- State: live pend[NUM_REGS], tag[NUM_REGS]; snapshots spend[NUM_CKPT][NUM_REGS], stag[NUM_CKPT][NUM_REGS].
- Reset (synchronous): all pend/spend = 0, all tags = 0. Outputs are therefore 0 in the cycle after reset.
- CDB match: m[i] = cdb_valid && pend[i] && tag[i]==cdb_tag.
  - regfile_wen_onehot = m, combinational.
  - Matching entries clear pend next edge.
- Read ports are combinational with CDB bypass: rsvalid = pend[rsaddr] && !m[rsaddr]; rstag = tag[rsaddr]. RT is identical.
- Read ports have no bypass of the same-cycle dispatch write; sources are read before the destination is renamed.
- Dispatch write: pend[addr] <= 1, tag[addr] <= dispatch_tag.
  - Dispatch write and CDB clear on the same register in the same cycle: dispatch wins.
- ZERO_REG=1: writes to register 0 are dropped, pend[0] is always 0 and regfile_wen_onehot[0] is always 0.
- Snapshot clearing: every cycle, snapshot entries with cdb_valid && spend && stag==cdb_tag clear, independent of save/restore.
- Save: slot ckpt_save_id <= live state after this cycle's CDB clear and before this cycle's dispatch write. The branch does not rename younger destinations.
- Restore, single cycle:
  - live <= slot ckpt_restore_id with this cycle's CDB clear applied.
  - Same-cycle dispatch write and ckpt_save are ignored.
  - regfile_wen_onehot still reflects pre-restore live state.
- Save and restore to the same slot in the same cycle: restore wins, slot contents unchanged except CDB clearing.
- Slot allocation/freeing is owned by the branch unit; restoring an unsaved slot yields its reset/last contents with no error.
- Reset mid-operation (any inputs asserted): reset dominates everything.
- Priority per entry, highest first: reset > restore > dispatch write > CDB clear > hold.

Decomposition:
- Shared package: TAG_W, ADDR_W and NUM_REGS defaults; rst_entry_t {pend, tag} typedef; a ZERO_REG_ADDR constant.
- One natural sub-module, rst_ckpt_slot: one snapshot bank with save, CDB-clear and read-out. Instantiate it NUM_CKPT times.

Test Plan:
- Reset, then dispatch reg 5 tag 12; read rs=5 next cycle -> rsvalid=1, rstag=12. Read rt=6 -> rtvalid=0.
- Reg 5 pending tag 12; cdb_valid=1 tag 12 -> same cycle regfile_wen_onehot=0x20 and rsvalid(5)=0 via bypass. Next cycle pend[5]=0.
- Same cycle dispatch reg 7 tag 3 and CDB tag 9 with reg 7 pending tag 9 -> next cycle reg 7 pending tag 3. Dispatch to reg 0 -> never pending, wen bit 0 stays 0.
- Reg 2 tag 4 pending; save slot 1; dispatch reg 2 tag 8; restore slot 1 -> reg 2 pending tag 4.
- Same as previous, but CDB tag 4 fires between save and restore -> after restore reg 2 not pending.
- Restore and dispatch (reg 9 tag 20) in the same cycle -> reg 9 unchanged. Reset asserted during restore -> all entries clear.
